// File: rtl/jtdd_scan2x_if.sv
// Video bundle between the colour mixer and the line doubler: 15 kHz pixel
// stream in, 31 kHz doubled stream out.
interface jtdd_scan2x_if;
  logic       pxl_cen;
  logic       pxl2_cen;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       LHBL;
  logic       LVBL;
  logic [3:0] sd_red;
  logic [3:0] sd_green;
  logic [3:0] sd_blue;
  logic       sd_LHBL;
  logic       sd_LVBL;
  logic       sd_HS;
  logic       ovf;

  modport master (
    output pxl_cen, pxl2_cen, red, green, blue, LHBL, LVBL,
    input  sd_red, sd_green, sd_blue, sd_LHBL, sd_LVBL, sd_HS, ovf
  );

  modport slave (
    input  pxl_cen, pxl2_cen, red, green, blue, LHBL, LVBL,
    output sd_red, sd_green, sd_blue, sd_LHBL, sd_LVBL, sd_HS, ovf
  );
endinterface

// File: rtl/jtdd_scan2x.sv
// Line-doubling scan converter: each active input line is written into one half
// of a ping-pong buffer while the other half is replayed twice at pxl2 rate.
module jtdd_scan2x #(
  parameter int         AW       = 8,
  parameter logic [8:0] HS_START = 9'd280,
  parameter logic [8:0] HS_LEN   = 9'd24
) (
  input  logic         clk,
  input  logic         rst_n,
  jtdd_scan2x_if.slave vid
);

  localparam int         DEPTH  = 1 << (AW + 1);
  localparam logic [9:0] HS_ON  = {1'b0, HS_START};
  localparam logic [9:0] HS_OFF = {1'b0, HS_START} + {1'b0, HS_LEN};

  logic          lhbl_last_q, lhbl_last_d;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    htotal_q, htotal_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [AW:0]   alen_q, alen_d;
  logic          wr_sel_q, wr_sel_d;
  logic          lvbl_q, lvbl_d;
  logic [1:0]    valid_cnt_q, valid_cnt_d;
  logic          ovf_q, ovf_d;
  logic [9:0]    rcnt_q, rcnt_d;

  logic          act1_q, hs1_q, lvbl1_q;
  logic [11:0]   rd_data_q;
  logic          sd_lhbl_q, sd_lhbl_d;
  logic          sd_hs_q, sd_hs_d;
  logic          sd_lvbl_q, sd_lvbl_d;
  logic [11:0]   sd_rgb_q, sd_rgb_d;

  logic          edge_s;
  logic          we_s;
  logic          active_s;
  logic          hs_s;
  logic [AW:0]   wr_addr_s;
  logic [AW:0]   rd_addr_s;
  logic [11:0]   pix_in_s;

  logic [11:0]   buf_mem [0:DEPTH-1];

  // wcnt saturates at 2^AW, so its MSB alone flags a full line
  assign edge_s    = vid.pxl_cen & lhbl_last_q & ~vid.LHBL;
  assign we_s      = vid.pxl_cen & vid.LHBL & ~wcnt_q[AW];
  assign wr_addr_s = {wr_sel_q, wcnt_q[AW-1:0]};
  assign rd_addr_s = {~wr_sel_q, rcnt_q[AW-1:0]};
  assign pix_in_s  = {vid.red, vid.green, vid.blue};

  // Input-side next state: line measurement, write pointer and line bookkeeping
  always_comb begin
    lhbl_last_d = lhbl_last_q;
    hcnt_d      = hcnt_q;
    htotal_d    = htotal_q;
    wcnt_d      = wcnt_q;
    alen_d      = alen_q;
    wr_sel_d    = wr_sel_q;
    lvbl_d      = lvbl_q;
    valid_cnt_d = valid_cnt_q;
    ovf_d       = ovf_q;
    if (vid.pxl_cen) begin
      lhbl_last_d = vid.LHBL;
      if (edge_s) begin
        htotal_d = hcnt_q + 10'd1;
        hcnt_d   = 10'd0;
        alen_d   = wcnt_q;
        wcnt_d   = '0;
        wr_sel_d = ~wr_sel_q;
        lvbl_d   = vid.LVBL;
        if (valid_cnt_q != 2'd2) begin
          valid_cnt_d = valid_cnt_q + 2'd1;
        end else begin
          valid_cnt_d = valid_cnt_q;
        end
      end else begin
        if (hcnt_q != 10'h3FF) begin
          hcnt_d = hcnt_q + 10'd1;
        end else begin
          hcnt_d = hcnt_q;
        end
        if (vid.LHBL && wcnt_q[AW]) begin
          ovf_d = 1'b1;
        end else if (vid.LHBL) begin
          wcnt_d = wcnt_q + {{AW{1'b0}}, 1'b1};
        end else begin
          wcnt_d = wcnt_q;
        end
      end
    end else begin
      lhbl_last_d = lhbl_last_q;
    end
  end

  // Output-side read counter; a line end resync always wins over the wrap
  always_comb begin
    rcnt_d = rcnt_q;
    if (edge_s || (htotal_q < 10'd2)) begin
      rcnt_d = 10'd0;
    end else if (vid.pxl2_cen && (rcnt_q >= (htotal_q - 10'd1))) begin
      rcnt_d = 10'd0;
    end else if (vid.pxl2_cen) begin
      rcnt_d = rcnt_q + 10'd1;
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  assign active_s = (valid_cnt_q == 2'd2) && (htotal_q >= 10'd2) &&
                    ({1'b0, rcnt_q} < 11'(alen_q));
  assign hs_s     = (rcnt_q >= HS_ON) && (rcnt_q < HS_OFF);

  // Final output stage; colour is blanked outside the active window
  always_comb begin
    sd_lhbl_d = act1_q;
    sd_hs_d   = hs1_q;
    sd_lvbl_d = lvbl1_q;
    if (act1_q) begin
      sd_rgb_d = rd_data_q;
    end else begin
      sd_rgb_d = 12'd0;
    end
  end

  // Line buffer: write on the input side, synchronous read for the output side
  always_ff @(posedge clk) begin
    if (we_s) begin
      buf_mem[wr_addr_s] <= pix_in_s;
    end
    rd_data_q <= buf_mem[rd_addr_s];
  end

  // Input-side state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_last_q <= 1'b0;
      hcnt_q      <= 10'd0;
      htotal_q    <= 10'd0;
      wcnt_q      <= '0;
      alen_q      <= '0;
      wr_sel_q    <= 1'b0;
      lvbl_q      <= 1'b0;
      valid_cnt_q <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      lhbl_last_q <= lhbl_last_d;
      hcnt_q      <= hcnt_d;
      htotal_q    <= htotal_d;
      wcnt_q      <= wcnt_d;
      alen_q      <= alen_d;
      wr_sel_q    <= wr_sel_d;
      lvbl_q      <= lvbl_d;
      valid_cnt_q <= valid_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Read counter plus the two-stage pipeline that keeps controls aligned with RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q    <= 10'd0;
      act1_q    <= 1'b0;
      hs1_q     <= 1'b0;
      lvbl1_q   <= 1'b0;
      sd_lhbl_q <= 1'b0;
      sd_hs_q   <= 1'b0;
      sd_lvbl_q <= 1'b0;
      sd_rgb_q  <= 12'd0;
    end else begin
      rcnt_q    <= rcnt_d;
      act1_q    <= active_s;
      hs1_q     <= hs_s;
      lvbl1_q   <= lvbl_q;
      sd_lhbl_q <= sd_lhbl_d;
      sd_hs_q   <= sd_hs_d;
      sd_lvbl_q <= sd_lvbl_d;
      sd_rgb_q  <= sd_rgb_d;
    end
  end

  assign vid.sd_red   = sd_rgb_q[11:8];
  assign vid.sd_green = sd_rgb_q[7:4];
  assign vid.sd_blue  = sd_rgb_q[3:0];
  assign vid.sd_LHBL  = sd_lhbl_q;
  assign vid.sd_LVBL  = sd_lvbl_q;
  assign vid.sd_HS    = sd_hs_q;
  assign vid.ovf      = ovf_q;

endmodule

// File: tb/tb_jtdd_scan2x.sv
// Scoreboard bench for jtdd_scan2x: each input line end queues the expected
// per-clock output for the following doubled lines; a monitor compares them.
module tb_jtdd_scan2x;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtdd_scan2x_if vif();

  jtdd_scan2x #(.AW(8), .HS_START(9'd280), .HS_LEN(9'd24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  typedef struct {
    int         cyc;
    logic       lhbl;
    logic       hs;
    logic       lvbl;
    logic [11:0] rgb;
  } rec_t;

  rec_t sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model of the input side
  logic        m_prev_lhbl;
  int          m_pcount, m_wcount, m_alen, m_valid;
  logic [11:0] cur_pix [256];
  logic [11:0] shown_pix [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_out(input string name, input logic lh, input logic hs,
                           input logic lv, input logic [11:0] rgb);
    logic [14:0] got, exp;
    got = {vif.sd_LHBL, vif.sd_HS, vif.sd_LVBL, vif.sd_red, vif.sd_green, vif.sd_blue};
    exp = {lh, hs, lv, rgb};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got lhbl=%b hs=%b lvbl=%b rgb=%h expected lhbl=%b hs=%b lvbl=%b rgb=%h",
               name, cyc, got[14], got[13], got[12], got[11:0], lh, hs, lv, rgb);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_lhbl = 1'b0;
    m_pcount = 0;
    m_wcount = 0;
    m_alen = 0;
    m_valid = 0;
    sbq.delete();
  endtask

  // One input pixel = two clk: a pxl_cen cycle then the extra pxl2_cen cycle
  task automatic drive_pixel(input logic lhbl, input logic lvbl, input logic [11:0] px, input int d);
    rec_t rec;
    int   h, r;
    @(negedge clk);
    vif.pxl_cen = 1'b1;
    vif.pxl2_cen = 1'b1;
    vif.LHBL = lhbl;
    vif.LVBL = lvbl;
    {vif.red, vif.green, vif.blue} = px;
    m_pcount++;
    if (m_prev_lhbl && !lhbl) begin
      h = m_pcount;
      shown_pix = cur_pix;
      m_alen = m_wcount;
      if (m_valid < 2) m_valid++;
      for (int j = 0; j < d; j++) begin
        r = (h < 2) ? 0 : (j % h);
        rec.cyc  = cyc + 3 + j;
        rec.lhbl = (m_valid == 2) && (h >= 2) && (r < m_alen);
        rec.hs   = (r >= 280) && (r < 304);
        rec.lvbl = lvbl;
        rec.rgb  = rec.lhbl ? shown_pix[r] : 12'h000;
        sbq.push_back(rec);
      end
      m_pcount = 0;
      m_wcount = 0;
    end else if (lhbl && (m_wcount < 256)) begin
      cur_pix[m_wcount] = px;
      m_wcount++;
    end
    m_prev_lhbl = lhbl;
    @(negedge clk);
    vif.pxl_cen = 1'b0;
  endtask

  // Active pixels (ramp from seed), then blank; the first blank pixel is the line end
  task automatic drive_line(input int act, input int blank, input logic lvbl,
                            input int seed, input int next_act);
    for (int i = 0; i < act; i++) drive_pixel(1'b1, lvbl, 12'(seed + i), 0);
    for (int i = 0; i < blank; i++) drive_pixel(1'b0, lvbl, 12'h000, 2 * (blank + next_act));
  endtask

  // Monitor: pop the record due this cycle, otherwise the output must be idle
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL stale_record cyc=%0d record_cyc=%0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        rec_t rec;
        rec = sbq.pop_front();
        check_out("stream", rec.lhbl, rec.hs, rec.lvbl, rec.rgb);
      end else begin
        check_out("idle", 1'b0, 1'b0, 1'b0, 12'h000);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.pxl_cen = 1'b0;
    vif.pxl2_cen = 1'b0;
    vif.red = 4'h0;
    vif.green = 4'h0;
    vif.blue = 4'h0;
    vif.LHBL = 1'b0;
    vif.LVBL = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_out("reset_outs", 1'b0, 1'b0, 1'b0, 12'h000);
    check_bit("reset_ovf", vif.ovf, 1'b0);

    // Release mid-line, short first line, then nominal lines with an LVBL gap
    rst_n = 1'b1;
    drive_line(100, 128, 1'b1, 500, 256);
    for (int k = 1; k <= 22; k++) begin
      drive_line(256, 128, (k >= 4 && k < 20) ? 1'b0 : 1'b1, (k - 1) * 37,
                 (k == 22) ? 0 : 256);
    end
    check_bit("nominal_no_ovf", vif.ovf, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check_out("reset_a_outs", 1'b0, 1'b0, 1'b0, 12'h000);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Overflow line of 300 pixels, then reset while a doubled line is active
    drive_line(256, 128, 1'b1, 100, 300);
    check_bit("ovf_before", vif.ovf, 1'b0);
    drive_line(300, 84, 1'b1, 0, 256);
    check_bit("ovf_set", vif.ovf, 1'b1);
    drive_line(256, 128, 1'b1, 700, 256);
    drive_line(256, 76, 1'b1, 1200, 0);
    check_bit("ovf_sticky", vif.ovf, 1'b1);
    check_bit("active_before_reset", vif.sd_LHBL, 1'b1);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check_out("async_reset_outs", 1'b0, 1'b0, 1'b0, 12'h000);
    check_bit("async_reset_ovf", vif.ovf, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdd_scan2x.md
# jtdd_scan2x

Line-doubling scan converter placed directly downstream of the video block. It takes the 15 kHz 12-bit RGB pixel stream and its delayed active-low blanking signals from the colour mixer. It writes each active line into one half of a ping-pong line buffer while the other half is read out twice at double pixel rate, producing a 31 kHz stream with regenerated horizontal sync for VGA-class outputs.

## Interface
Parameters:
- AW, 8, line-buffer address width; maximum stored active pixels per line = 2^AW
- HS_START, 9'd280, output-line tick (pxl2_cen units) where sd_HS rises
- HS_LEN, 9'd24, sd_HS pulse width in pxl2_cen ticks

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pxl_cen  in  1  input pixel clock enable
- pxl2_cen  in  1  double-rate enable; every pxl_cen cycle is also a pxl2_cen cycle, and exactly one extra pxl2_cen lies between consecutive pxl_cen
- red, green, blue  in  4 each  input pixel, valid on pxl_cen
- LHBL  in  1  input horizontal blank, active low (delayed blank from colour mixer)
- LVBL  in  1  input vertical blank, active low
- sd_red, sd_green, sd_blue  out  4 each  doubled pixel
- sd_LHBL  out  1  output horizontal blank, active low
- sd_LVBL  out  1  output vertical blank, active low
- sd_HS  out  1  output horizontal sync, active high
- ovf  out  1  sticky: an input line exceeded 2^AW active pixels

## Operation
- Input side, on pxl_cen only:
  - hcnt counts pixels per input line.
  - A LHBL falling edge (1→0, sampled on pxl_cen) marks end of line. On it: htotal←hcnt+1; hcnt←0; alen←wcnt; wcnt←0; wr_sel toggles; lvbl_q←LVBL; valid_cnt increments, saturating at 2.
  - While LHBL=1: write {red,green,blue} to buffer[wr_sel][wcnt] and increment wcnt.
  - When wcnt reaches 2^AW: drop further writes; wcnt holds at 2^AW; ovf←1.
- Output side, on pxl2_cen only:
  - rcnt counts 0..htotal-1, then wraps to 0. Each wrap is one output line, so two output lines fit per input line.
  - rcnt is forced to 0 on the pxl2_cen of a detected LHBL falling edge. This resync overrides the wrap.
  - Reads come from buffer[~wr_sel] at address rcnt[AW-1:0].
  - Output is active when valid_cnt==2 and rcnt<alen.
  - sd_LHBL = active.
  - sd_LVBL = lvbl_q, updated at resync only, so it lags the input by one line.
  - sd_HS = 1 when HS_START ≤ rcnt < HS_START+HS_LEN. Comparison is 10-bit, with no wrap.
  - RGB outputs are forced to 0 whenever sd_LHBL=0.
- Buffers: two 2^AW×12 single-port-write, synchronous-read RAMs, or one 2^(AW+1)×12 RAM indexed by the select bit.
- Widths:
  - hcnt, htotal, rcnt: 10 bits. hcnt saturates at 1023.
  - alen: AW+1 bits.
  - If htotal<2 the output side holds rcnt=0 and sd_LHBL=0.

## Timing
- Reset (rst_n=0, asynchronous):
  - All outputs 0: sd_LHBL=0, sd_LVBL=0, sd_HS=0, RGB=0, ovf=0.
  - hcnt, wcnt, rcnt, alen, htotal, valid_cnt, wr_sel cleared.
- The first two input line ends after reset produce no active output. Output becomes active from the line following the second LHBL falling edge.
- Read latency: rcnt to sd_* is 2 clk (RAM read plus output register). sd_LHBL and sd_HS are delayed identically so all outputs stay aligned.
- Input pixel to its first appearance on output: one input line plus 2 clk.
- Reset deassertion mid-line: hcnt starts from 0. The first LHBL falling edge yields a short htotal, but valid_cnt still blanks that line.
- Read and write never address the same buffer half within a line, because the toggle and resync occur in the same cycle.
- Simultaneous events: an LHBL falling edge and an rcnt wrap in the same cycle give rcnt=0, with no double increment.

## Test plan
- Nominal: htotal=384, 256 active pixels, ramp value = pixel index → each input line gives two output lines of 384 pxl2 ticks, 256 active pixels each, sd_red/green/blue equal to the ramp, and both copies identical.
- Startup: release reset, then feed 3 lines → sd_LHBL stays 0 for lines 0–1; active output begins after the 2nd LHBL falling edge, with line-0 data never shown.
- Sync: HS_START=280, HS_LEN=24, htotal=384 → sd_HS is high for rcnt 280–303 twice per input line, and is 2 clk after the rcnt match.
- Overflow: AW=8, 300 active pixels → alen=256, pixels 256–299 discarded, ovf=1 and held until rst_n low.
- Vertical: drop LVBL for 16 lines → sd_LVBL is low for 32 output lines, starting one input line later.
- Asynchronous reset mid-line with rcnt=150 → all outputs 0 immediately, with no pxl2_cen needed.
